ddr_write_arbiter: RTL
======================

Name: ddr_write_arbiter

Overview:
- Shares the single PL-to-PS DDR4 write engine between two writers.
  - Requester 0: postmortem capture.
  - Requester 1: a second logger, e.g. fault/waveform snapshot.
- Each requester uses the existing start/addr/data/done protocol:
  - start is held high for a burst of one or more beats.
  - done pulses once per beat.
- The arbiter grants one requester for its whole burst and muxes its address and data onto the writer port.
- It counts beats per requester and, optionally, recovers from a stalled writer.

Parameters:
- ADDR_W, 40, DDR address width.
- DATA_W, 64, write data width.
- FIXED_PRI, 0, arbitration mode: 0 = round-robin, 1 = requester 0 always wins ties.
- TIMEOUT, 4000, cycles to wait for i_done per beat (20 us at 200 MHz); used only with DDR_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-low reset
- i_req0_start  in  1  requester 0 burst request, held high until its last beat completes
- i_req0_addr  in  ADDR_W  requester 0 beat address
- i_req0_data  in  DATA_W  requester 0 beat data
- o_req0_done  out  1  requester 0 beat-complete pulse
- i_req1_start / i_req1_addr / i_req1_data / o_req1_done  same as requester 0, for requester 1
- o_start  out  1  writer request
- o_ddr_addr  out  ADDR_W  writer address
- o_ddr_data  out  DATA_W  writer data
- i_done  in  1  writer beat-complete pulse
- o_grant  out  2  one-hot current owner; 00 = none
- o_beat_cnt0  out  32  beats completed for requester 0
- o_beat_cnt1  out  32  beats completed for requester 1
- o_timeout  out  1  sticky timeout flag (held 0 without the feature)
- i_timeout_clr  in  1  clears o_timeout and o_timeout_cnt
- o_timeout_cnt  out  8  saturating timeout count (held 0 without the feature)

Behaviour:
- Reset (i_rst low, asynchronous):
  - State goes to IDLE; round-robin pointer goes to 0 (requester 0 preferred).
  - All outputs are 0.
  - A reset mid-burst drops o_start immediately; no done is generated for the aborted beat.
- States: IDLE, GNT0, GNT1, GAP.
- IDLE:
  - If only one start is high, go to that GNTn.
  - If both are high and FIXED_PRI=1, go to GNT0.
  - If both are high and FIXED_PRI=0, grant the requester not granted last. The pointer updates on entry to GNTn.
  - Grant latency: start rising at cycle N gives o_grant and o_start at cycle N+1.
- GNTn:
  - o_start = i_reqn_start, combinational.
  - o_ddr_addr and o_ddr_data mux from requester n, combinational, so the writer sees the requester's registers with zero added latency.
  - o_reqn_done = i_done, combinational.
  - The other requester's done is held 0.
  - Stay while i_reqn_start = 1. When it drops, go to GAP.
- GAP: exactly one cycle with o_start=0 and o_grant=00, then IDLE. This guarantees a start low edge between owners and between back-to-back bursts of the same owner.
- Outside GNTn, o_ddr_addr and o_ddr_data hold their last granted values (registered copy); o_start=0.
- i_done while not in GNTn is ignored and not counted.
- o_beat_cntn:
  - Increments on each o_reqn_done pulse; wraps from 0xFFFF_FFFF to 0.
- If the owner drops start in the same cycle as i_done:
  - The done is still passed through and counted.
  - The next state is GAP.
- A request arriving during GAP waits in IDLE; it is granted at the earliest 2 cycles after release.

Optional Feature:
- Macro: DDR_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit beat timer runs in GNTn while o_start=1. It clears on i_done or on state entry.
  - When it reaches TIMEOUT-1:
    - Generate a 1-cycle synthetic o_reqn_done so the requester advances.
    - Do not increment o_beat_cntn.
    - Set o_timeout.
    - Increment o_timeout_cnt, saturating at 255.
    - Restart the timer.
  - i_timeout_clr zeroes o_timeout and o_timeout_cnt. If a timeout fires in the same cycle, the timeout wins.
- When not defined: no timer; o_timeout and o_timeout_cnt are tied to 0; the arbiter waits indefinitely for i_done.

Test Plan:
- Req0 alone, 5-beat burst, writer answers done 10 cycles after each start edge:
  - o_grant=01 one cycle after start.
  - 5 done pulses reach req0.
  - o_beat_cnt0=5; GAP observed; o_grant returns to 00.
- Req0 and req1 raise start in the same cycle, FIXED_PRI=0, after reset:
  - Req0 is served first, then GAP, then req1.
  - Repeat the simultaneous request: req1 is served first.
- Same as the previous scenario with FIXED_PRI=1:
  - Req0 wins both times.
- Req1 raises start mid req0 burst:
  - Req1's address/data never appear on o_ddr_addr and o_ddr_data while o_grant=01.
  - o_req1_done stays 0 until GNT1.
- i_rst pulsed low during beat 3 of a req1 burst:
  - All outputs are 0 immediately.
  - After release, a fresh req1 burst is granted and o_beat_cnt1 restarts from 0.
- With DDR_ARB_TIMEOUT_EN and TIMEOUT=100, writer never asserts done:
  - Synthetic done at 100 cycles after start; o_timeout=1; o_timeout_cnt=1; o_beat_cnt0 unchanged.
  - Pulse i_timeout_clr: both return to 0.

Source files
------------

// File: rtl/ddr_write_arbiter.sv
// Shares one DDR write engine between two start/addr/data/done writers; grant is held for a whole burst.
// Grant one cycle after start; beat watchdog is built only with `define DDR_ARB_TIMEOUT_EN.
module ddr_write_arbiter #(
  parameter int ADDR_W    = 40,
  parameter int DATA_W    = 64,
  parameter int FIXED_PRI = 0,
  parameter int TIMEOUT   = 4000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_start,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_done,
  input  logic              i_req1_start,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_done,
  output logic              o_start,
  output logic [ADDR_W-1:0] o_ddr_addr,
  output logic [DATA_W-1:0] o_ddr_data,
  input  logic              i_done,
  output logic [1:0]        o_grant,
  output logic [31:0]       o_beat_cnt0,
  output logic [31:0]       o_beat_cnt1,
  output logic              o_timeout,
  input  logic              i_timeout_clr,
  output logic [7:0]        o_timeout_cnt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;  // 1 = requester 1 wins the next tie
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       cnt0_q, cnt1_q;
  logic              syn_done;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (i_req0_start && (!i_req1_start || FIXED_PRI != 0 || !ptr_q)) begin
          state_d = GNT0;
          ptr_d   = 1'b1;
        end else if (i_req1_start) begin
          state_d = GNT1;
          ptr_d   = 1'b0;
        end
      end
      GNT0:    if (!i_req0_start) state_d = GAP;
      GNT1:    if (!i_req1_start) state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  // Owner sees the writer directly; everyone else sees the last granted beat.
  always_comb begin
    o_start     = 1'b0;
    o_grant     = 2'b00;
    o_ddr_addr  = addr_q;
    o_ddr_data  = data_q;
    o_req0_done = 1'b0;
    o_req1_done = 1'b0;
    unique case (state_q)
      GNT0: begin
        o_start     = i_req0_start;
        o_grant     = 2'b01;
        o_ddr_addr  = i_req0_addr;
        o_ddr_data  = i_req0_data;
        o_req0_done = i_done | syn_done;
      end
      GNT1: begin
        o_start     = i_req1_start;
        o_grant     = 2'b10;
        o_ddr_addr  = i_req1_addr;
        o_ddr_data  = i_req1_data;
        o_req1_done = i_done | syn_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == GNT0 || state_q == GNT1) begin
        addr_q <= o_ddr_addr;
        data_q <= o_ddr_data;
      end
      if (state_q == GNT0 && i_done) cnt0_q <= cnt0_q + 32'd1;
      if (state_q == GNT1 && i_done) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign o_beat_cnt0 = cnt0_q;
  assign o_beat_cnt1 = cnt1_q;

`ifdef DDR_ARB_TIMEOUT_EN
  logic [15:0] tmr_q;
  logic [7:0]  to_cnt_q;
  logic        to_q;
  logic        tmr_run;

  assign tmr_run  = (state_q == GNT0 || state_q == GNT1) && o_start;
  // A real done in the firing cycle takes precedence over the synthetic one.
  assign syn_done = tmr_run && !i_done && (tmr_q == 16'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tmr_q    <= '0;
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (!tmr_run || i_done || syn_done) tmr_q <= '0;
      else                                tmr_q <= tmr_q + 16'd1;
      if (syn_done) begin
        to_q <= 1'b1;
        if (to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
      end else if (i_timeout_clr) begin
        to_q     <= 1'b0;
        to_cnt_q <= '0;
      end
    end
  end

  assign o_timeout     = to_q;
  assign o_timeout_cnt = to_cnt_q;
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_clr;
  assign unused_clr    = i_timeout_clr;
  assign syn_done      = 1'b0;
  assign o_timeout     = 1'b0;
  assign o_timeout_cnt = 8'd0;
`endif

endmodule
